// File: rtl/fetch_unit_if.sv
// Fetch unit bus: program ROM port, branch redirect and the decoded-instruction output.
// master is the fetch unit; slave is the ROM/branch/decode environment.
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  branch_valid;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_operand;
  logic                  out_long;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output rom_addr,
    input  rom_data,
    input  branch_valid,
    input  branch_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_operand,
    output out_long,
    output out_pc
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output branch_valid,
    output branch_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_operand,
    input  out_long,
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the program ROM, joins two-word instructions
// (lds/sts/jmp/call) into one output beat, stalls on decode backpressure and
// redirects on branch.
module fetch_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {StStart, StWord1, StWord2} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_hold_word, w_hold_word_nxt;
  logic [ADDR_WIDTH-1:0] r_hold_pc, w_hold_pc_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [DATA_WIDTH-1:0] r_out_instr, w_out_instr_nxt;
  logic [DATA_WIDTH-1:0] r_out_operand, w_out_operand_nxt;
  logic                  r_out_long, w_out_long_nxt;
  logic [ADDR_WIDTH-1:0] r_out_pc, w_out_pc_nxt;

  logic w_free;
  logic w_two_word;

  function automatic logic f_two_word(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] w_m0;
    logic [DATA_WIDTH-1:0] w_m1;
    w_m0 = w & DATA_WIDTH'(16'hFE0F);
    w_m1 = w & DATA_WIDTH'(16'hFE0E);
    return (w_m0 == DATA_WIDTH'(16'h9000)) || (w_m0 == DATA_WIDTH'(16'h9200)) ||
           (w_m1 == DATA_WIDTH'(16'h940C)) || (w_m1 == DATA_WIDTH'(16'h940E));
  endfunction

  // Output register can take a new beat when empty or being consumed this edge.
  assign w_free     = !r_out_valid || bus.out_ready;
  assign w_two_word = f_two_word(bus.rom_data);

  // Next-state: branch wins everywhere, otherwise walk START -> WORD1 <-> WORD2.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_hold_word_nxt   = r_hold_word;
    w_hold_pc_nxt     = r_hold_pc;
    w_out_valid_nxt   = r_out_valid;
    w_out_instr_nxt   = r_out_instr;
    w_out_operand_nxt = r_out_operand;
    w_out_long_nxt    = r_out_long;
    w_out_pc_nxt      = r_out_pc;

    if (bus.branch_valid) begin
      // Redirect drops any pending or half-assembled instruction.
      w_pc_nxt        = bus.branch_target;
      w_out_valid_nxt = 1'b0;
      w_hold_word_nxt = '0;
      w_hold_pc_nxt   = '0;
      w_state_nxt     = StWord1;
    end else begin
      unique case (r_state)
        // ROM has not latched address 0 yet; wait one edge.
        StStart: w_state_nxt = StWord1;
        StWord1: begin
          if (w_free) begin
            w_pc_nxt = r_pc + ADDR_WIDTH'(1);
            if (w_two_word) begin
              w_hold_word_nxt = bus.rom_data;
              w_hold_pc_nxt   = r_pc;
              w_out_valid_nxt = 1'b0;
              w_state_nxt     = StWord2;
            end else begin
              w_out_instr_nxt   = bus.rom_data;
              w_out_operand_nxt = '0;
              w_out_long_nxt    = 1'b0;
              w_out_pc_nxt      = r_pc;
              w_out_valid_nxt   = 1'b1;
            end
          end
        end
        // Output is empty on entry here, so the operand can always be taken.
        StWord2: begin
          w_out_instr_nxt   = r_hold_word;
          w_out_operand_nxt = bus.rom_data;
          w_out_long_nxt    = 1'b1;
          w_out_pc_nxt      = r_hold_pc;
          w_out_valid_nxt   = 1'b1;
          w_pc_nxt          = r_pc + ADDR_WIDTH'(1);
          w_state_nxt       = StWord1;
        end
        default: w_state_nxt = StStart;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StStart;
      r_pc          <= '0;
      r_hold_word   <= '0;
      r_hold_pc     <= '0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_operand <= '0;
      r_out_long    <= 1'b0;
      r_out_pc      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_hold_word   <= w_hold_word_nxt;
      r_hold_pc     <= w_hold_pc_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_instr   <= w_out_instr_nxt;
      r_out_operand <= w_out_operand_nxt;
      r_out_long    <= w_out_long_nxt;
      r_out_pc      <= w_out_pc_nxt;
    end
  end

  assign bus.rom_addr    = r_pc;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_instr   = r_out_instr;
  assign bus.out_operand = r_out_operand;
  assign bus.out_long    = r_out_long;
  assign bus.out_pc      = r_out_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: falling-edge ROM model, an instruction-stream scoreboard
// checked every valid cycle, and directed timing checks with literal values.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [15:0] rom [256];

  fetch_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program ROM registers its word on the falling edge.
  always @(negedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Two-word opcodes by field: lds/sts are 100100x.....0000, jmp/call are 1001010.....11x.
  function automatic bit two_word(input logic [15:0] w);
    return (w[15:10] == 6'b100100 && w[3:0] == 4'h0) ||
           (w[15:9] == 7'b1001010 && w[3:2] == 2'b11);
  endfunction

  // Scoreboard: m_addr is the address of the next instruction decode must see.
  logic [7:0] m_addr;
  always @(negedge clk) begin
    logic [15:0] w;
    logic [7:0]  nxt;
    if (!rst_n) begin
      m_addr = 8'd0;
    end else begin
      w   = rom[m_addr];
      nxt = m_addr + 8'd1;
      if (bus.out_valid) begin
        chk("model_instr", 32'(bus.out_instr), 32'(w));
        chk("model_pc", 32'(bus.out_pc), 32'(m_addr));
        chk("model_long", 32'(bus.out_long), 32'(two_word(w)));
        chk("model_operand", 32'(bus.out_operand), two_word(w) ? 32'(rom[nxt]) : 32'd0);
      end
      if (bus.branch_valid) m_addr = bus.branch_target;
      else if (bus.out_valid && bus.out_ready) m_addr = m_addr + (two_word(w) ? 8'd2 : 8'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic branch_to(input logic [7:0] t);
    bus.branch_valid  = 1'b1;
    bus.branch_target = t;
    step(1);
    bus.branch_valid  = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0]   = 16'hE005;
    rom[1]   = 16'hE01F;
    rom[2]   = 16'h930F;
    rom[3]   = 16'hE123;
    rom[12]  = 16'h930F;
    rom[16]  = 16'h9300;
    rom[17]  = 16'h0100;
    rom[20]  = 16'h9000;
    rom[21]  = 16'hABCD;
    rom[22]  = 16'h940E;
    rom[23]  = 16'h1234;
    rom[24]  = 16'h9401;
    rom[255] = 16'hE0FF;

    rst_n             = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 8'd0;
    bus.out_ready     = 1'b1;
    step(3);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", 32'(bus.out_instr), 32'd0);
    chk("rst_operand", 32'(bus.out_operand), 32'd0);
    chk("rst_long", 32'(bus.out_long), 32'd0);
    chk("rst_pc", 32'(bus.out_pc), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);

    // First instruction appears on the second edge after release.
    rst_n = 1'b1;
    step(1);
    chk("start_valid", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_instr", 32'(bus.out_instr), 32'hE005);
    chk("first_pc", 32'(bus.out_pc), 32'd0);
    step(1);
    chk("second_instr", 32'(bus.out_instr), 32'hE01F);
    chk("second_pc", 32'(bus.out_pc), 32'd1);
    chk("second_long", 32'(bus.out_long), 32'd0);
    step(1);
    chk("third_instr", 32'(bus.out_instr), 32'h930F);
    chk("third_addr", 32'(bus.rom_addr), 32'd3);

    // Backpressure holds everything.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_instr", 32'(bus.out_instr), 32'h930F);
      chk("stall_pc", 32'(bus.out_pc), 32'd2);
      chk("stall_addr", 32'(bus.rom_addr), 32'd3);
    end
    bus.out_ready = 1'b1;
    step(1);
    chk("release_instr", 32'(bus.out_instr), 32'hE123);
    chk("release_pc", 32'(bus.out_pc), 32'd3);

    // Branch while stalled drops the pending beat.
    bus.out_ready = 1'b0;
    step(1);
    chk("stall2_pc", 32'(bus.out_pc), 32'd3);
    branch_to(8'd12);
    chk("br_stall_valid", 32'(bus.out_valid), 32'd0);
    chk("br_stall_addr", 32'(bus.rom_addr), 32'd12);
    bus.out_ready = 1'b1;
    step(1);
    chk("br_stall_instr", 32'(bus.out_instr), 32'h930F);
    chk("br_stall_pc", 32'(bus.out_pc), 32'd12);
    chk("br_stall_v", 32'(bus.out_valid), 32'd1);

    // Branch to a two-word sts.
    branch_to(8'd16);
    chk("br16_valid0", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("br16_valid1", 32'(bus.out_valid), 32'd0);
    chk("br16_addr17", 32'(bus.rom_addr), 32'd17);
    step(1);
    chk("br16_instr", 32'(bus.out_instr), 32'h9300);
    chk("br16_operand", 32'(bus.out_operand), 32'h0100);
    chk("br16_long", 32'(bus.out_long), 32'd1);
    chk("br16_pc", 32'(bus.out_pc), 32'd16);
    chk("br16_addr18", 32'(bus.rom_addr), 32'd18);

    // Mixed stream under a fixed ready pattern; scoreboard checks each beat.
    pat = 16'b1011_0111_1101_1110;
    for (int i = 0; i < 16; i++) begin
      bus.out_ready = pat[i];
      step(1);
    end
    bus.out_ready = 1'b1;
    step(4);

    // PC wrap on a single-word instruction at the last address.
    branch_to(8'd255);
    chk("wrap_valid0", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("wrap_instr", 32'(bus.out_instr), 32'hE0FF);
    chk("wrap_pc", 32'(bus.out_pc), 32'd255);
    chk("wrap_addr", 32'(bus.rom_addr), 32'd0);
    step(1);
    chk("wrap_next_pc", 32'(bus.out_pc), 32'd0);
    chk("wrap_next_instr", 32'(bus.out_instr), 32'hE005);

    // Two-word jmp at the last address takes its operand from address 0.
    rom[255] = 16'h940C;
    branch_to(8'd255);
    step(1);
    chk("wrap2_addr", 32'(bus.rom_addr), 32'd0);
    step(1);
    chk("wrap2_instr", 32'(bus.out_instr), 32'h940C);
    chk("wrap2_operand", 32'(bus.out_operand), 32'hE005);
    chk("wrap2_long", 32'(bus.out_long), 32'd1);
    chk("wrap2_pc", 32'(bus.out_pc), 32'd255);
    chk("wrap2_addr1", 32'(bus.rom_addr), 32'd1);

    // Reset between the first word and the operand of sts.
    branch_to(8'd16);
    step(1);
    chk("mid_addr17", 32'(bus.rom_addr), 32'd17);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_addr", 32'(bus.rom_addr), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("mid_rel_valid", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("mid_first_instr", 32'(bus.out_instr), 32'hE005);
    chk("mid_first_pc", 32'(bus.out_pc), 32'd0);
    chk("mid_first_long", 32'(bus.out_long), 32'd0);
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
